matrixmult_feeder: RTL and testbench

Upstream stage of the matrixmult FSL core. Accepts a 4x4 float matrix and a stream of 4-element pixel vectors from the processor FSL link, and holds the matrix. For each pixel it emits the interleaved operand stream the matrixmult core consumes: row element, pixel element, repeated per row, 32 words per pixel. The output connects directly to the matrixmult FSL slave port.

---
 rtl/matrixmult_feeder.sv | 147 ++++++++++++++
 tb/tb_matrixmult_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrixmult_feeder.sv
// Operand feeder for the matrixmult FSL core: holds a 4x4 matrix and streams interleaved row/pixel words.
// Optional: define MATRIXMULT_FEEDER_LAST_EN to flag the last pixel word of each row on FSL_M_Control.
//
// state      | meaning
// S_IDLE     | waiting for the first word of a matrix or pixel group
// S_LOAD_MAT | receiving matrix words 1..15 into mat_q
// S_LOAD_PIX | receiving pixel words 1..3 into pix_q
// S_EMIT     | streaming 32 interleaved operand words downstream
module matrixmult_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4
) (
  input  logic                  FSL_Clk,
  input  logic                  FSL_Rst,
  output logic                  FSL_S_Read,
  input  logic [DATA_WIDTH-1:0] FSL_S_Data,
  input  logic                  FSL_S_Control,
  input  logic                  FSL_S_Exists,
  output logic                  FSL_M_Write,
  output logic [DATA_WIDTH-1:0] FSL_M_Data,
  output logic                  FSL_M_Control,
  input  logic                  FSL_M_Full,
  output logic                  matrix_valid,
  output logic                  err
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD_MAT = 2'd1;
  localparam logic [1:0] S_LOAD_PIX = 2'd2;
  localparam logic [1:0] S_EMIT     = 2'd3;

  localparam logic [4:0] MAT_LAST  = 5'(DIM * DIM - 1);
  localparam logic [4:0] PIX_LAST  = 5'(DIM - 1);
  localparam logic [4:0] EMIT_LAST = 5'(2 * DIM * DIM - 1);

  logic [1:0]            state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  mval_q, mval_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mat_q [DIM*DIM];
  logic [DATA_WIDTH-1:0] pix_q [DIM];

  logic       accept;
  logic       emit_write;
  logic       mat_we, pix_we;
  logic [3:0] wr_idx;

  // Read is gated by reset so nothing is popped while the block is held in reset.
  assign accept      = (state_q != S_EMIT) && FSL_S_Exists && FSL_Rst;
  assign emit_write  = (state_q == S_EMIT) && !FSL_M_Full;
  assign FSL_S_Read  = accept;
  assign FSL_M_Write = emit_write;

  // cnt[0] selects pixel vs matrix, cnt[2:1] the column, cnt[4:3] the row.
  assign FSL_M_Data = (state_q != S_EMIT) ? '0 :
                      cnt_q[0] ? pix_q[cnt_q[2:1]] : mat_q[{cnt_q[4:3], cnt_q[2:1]}];

`ifdef MATRIXMULT_FEEDER_LAST_EN
  assign FSL_M_Control = (state_q == S_EMIT) && (cnt_q[2:0] == 3'b111);
`else
  assign FSL_M_Control = 1'b0;
`endif

  assign matrix_valid = mval_q;
  assign err          = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mval_d  = mval_q;
    err_d   = err_q;
    mat_we  = 1'b0;
    pix_we  = 1'b0;
    wr_idx  = cnt_q[3:0];
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_idx = 4'd0;
          if (FSL_S_Control) begin
            mat_we  = 1'b1;
            mval_d  = 1'b0;
            cnt_d   = 5'd1;
            state_d = S_LOAD_MAT;
          end else if (mval_q) begin
            pix_we  = 1'b1;
            cnt_d   = 5'd1;
            state_d = S_LOAD_PIX;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_MAT: begin
        if (accept) begin
          mat_we = 1'b1;
          if (cnt_q == MAT_LAST) begin
            mval_d  = 1'b1;
            cnt_d   = 5'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_LOAD_PIX: begin
        if (accept) begin
          pix_we = 1'b1;
          if (cnt_q == PIX_LAST) begin
            cnt_d   = 5'd0;
            state_d = S_EMIT;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        if (emit_write) begin
          if (cnt_q == EMIT_LAST) begin
            cnt_d   = 5'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mval_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DIM*DIM; i++) mat_q[i] <= '0;
      for (int i = 0; i < DIM; i++) pix_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mval_q  <= mval_d;
      err_q   <= err_d;
      if (mat_we) mat_q[wr_idx] <= FSL_S_Data;
      if (pix_we) pix_q[wr_idx[1:0]] <= FSL_S_Data;
    end
  end

endmodule

// File: tb/tb_matrixmult_feeder.sv
// Directed bench for matrixmult_feeder; expected operand streams come from hand-written constants
// and the interleave definition (row element, pixel element), checked through one task.
module tb_matrixmult_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_read;
  logic [31:0] s_data = '0;
  logic        s_ctrl = 1'b0;
  logic        s_exists = 1'b0;
  logic        m_write;
  logic [31:0] m_data;
  logic        m_ctrl;
  logic        m_full = 1'b0;
  logic        mvalid;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [31:0] mat [16];
  logic [31:0] px [4];
  logic [31:0] got_d [32];
  logic        got_c [32];
  int          got_n;
  int          last_cyc;

  always #5 clk = ~clk;

  matrixmult_feeder #(.DATA_WIDTH(32), .DIM(4)) dut (
    .FSL_Clk(clk), .FSL_Rst(rst_n),
    .FSL_S_Read(s_read), .FSL_S_Data(s_data), .FSL_S_Control(s_ctrl), .FSL_S_Exists(s_exists),
    .FSL_M_Write(m_write), .FSL_M_Data(m_data), .FSL_M_Control(m_ctrl), .FSL_M_Full(m_full),
    .matrix_valid(mvalid), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    if (k % 2 == 1) return px[(k / 2) % 4];
    return mat[4 * (k / 8) + (k / 2) % 4];
  endfunction

  function automatic logic exp_ctrl(input int k);
`ifdef MATRIXMULT_FEEDER_LAST_EN
    return (k % 8) == 7;
`else
    return (k < 0);
`endif
  endfunction

  // Called just after a rising edge; leaves the bench just after the consuming edge.
  task automatic push(input logic [31:0] d, input logic c);
    s_exists = 1'b1;
    s_data   = d;
    s_ctrl   = c;
    #1;
    check("s_read", {31'd0, s_read}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic push_pixel();
    for (int i = 0; i < 4; i++) push(px[i], 1'b0);
    s_exists = 1'b0;
  endtask

  task automatic load_matrix();
    for (int i = 0; i < 16; i++) push(mat[i], (i == 0));
    s_exists = 1'b0;
  endtask

  // Gathers nstop output words; FSL_M_Full is held high for EMIT cycles flo..fhi.
  task automatic collect(input int nstop, input int flo, input int fhi);
    int cyc;
    cyc   = 0;
    got_n = 0;
    while (got_n < nstop && cyc < 200) begin
      m_full = (cyc >= flo) && (cyc <= fhi);
      #1;
      check("s_read_emit", {31'd0, s_read}, 32'd0);
      if (m_full) begin
        check("stall_write", {31'd0, m_write}, 32'd0);
        check("stall_data", m_data, exp_word(got_n));
      end else begin
        check("emit_write", {31'd0, m_write}, 32'd1);
        if (m_write) begin
          got_d[got_n] = m_data;
          got_c[got_n] = m_ctrl;
          got_n++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_full   = 1'b0;
    last_cyc = cyc;
    check("collect_count", got_n, nstop);
  endtask

  task automatic verify(input int n);
    for (int k = 0; k < n; k++) begin
      check("word_data", got_d[k], exp_word(k));
      check("word_ctrl", {31'd0, got_c[k]}, {31'd0, exp_ctrl(k)});
    end
  endtask

  logic [31:0] hand8 [8];
  logic [31:0] pix_a [4];
  logic [31:0] pix_b [4];

  initial begin
    mat = '{32'h4124CCCD, 32'h40C80000, 32'h40A9999A, 32'h3C4CCCCD,
            32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
    pix_a = '{32'hBF07AE14, 32'h4141999A, 32'hC1691EB8, 32'h4040A3D7};
    pix_b = '{32'h3E800000, 32'hBF000000, 32'h42C80000, 32'h00000000};
    hand8 = '{32'h4124CCCD, 32'hBF07AE14, 32'h40C80000, 32'h4141999A,
              32'h40A9999A, 32'hC1691EB8, 32'h3C4CCCCD, 32'h4040A3D7};

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mvalid", {31'd0, mvalid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_write", {31'd0, m_write}, 32'd0);
    check("rst_data", m_data, 32'd0);

    // 1: pixel without matrix
    push(32'hBF07AE14, 1'b0);
    s_exists = 1'b0;
    check("t1_err", {31'd0, err}, 32'd1);
    check("t1_mvalid", {31'd0, mvalid}, 32'd0);
    check("t1_write", {31'd0, m_write}, 32'd0);

    // 2: matrix load
    for (int i = 0; i < 15; i++) push(mat[i], (i == 0));
    check("t2_mvalid_early", {31'd0, mvalid}, 32'd0);
    push(mat[15], 1'b0);
    s_exists = 1'b0;
    check("t2_mvalid", {31'd0, mvalid}, 32'd1);

    // 3: one pixel, no stall
    px = pix_a;
    push_pixel();
    collect(32, -1, -1);
    verify(32);
    for (int k = 0; k < 8; k++) check("t3_hand", got_d[k], hand8[k]);
    check("t3_cycles", last_cyc, 32);
    check("t3_idle_write", {31'd0, m_write}, 32'd0);
    check("t3_idle_data", m_data, 32'd0);

    // 4: same pixel with a 4-cycle stall
    push_pixel();
    collect(32, 3, 6);
    verify(32);
    for (int k = 0; k < 8; k++) check("t4_hand", got_d[k], hand8[k]);
    check("t4_cycles", last_cyc, 36);

    // 5: back-to-back pixels, next word waiting during EMIT
    push_pixel();
    s_exists = 1'b1;
    s_data   = pix_b[0];
    s_ctrl   = 1'b0;
    collect(32, -1, -1);
    verify(32);
    px = pix_b;
    push_pixel();
    collect(32, -1, -1);
    verify(32);
    check("t5_mvalid", {31'd0, mvalid}, 32'd1);

    // 6: async reset at output word 10
    px = pix_a;
    push_pixel();
    collect(10, -1, -1);
    s_exists = 1'b1;
    s_ctrl   = 1'b1;
    #2;
    check("t6_pre_write", {31'd0, m_write}, 32'd1);
    check("t6_pre_data", m_data, exp_word(10));
    rst_n = 1'b0;
    #1;
    check("t6_write", {31'd0, m_write}, 32'd0);
    check("t6_data", m_data, 32'd0);
    check("t6_ctrl", {31'd0, m_ctrl}, 32'd0);
    check("t6_read", {31'd0, s_read}, 32'd0);
    check("t6_mvalid", {31'd0, mvalid}, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    s_exists = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check("t6_rel_mvalid", {31'd0, mvalid}, 32'd0);
    push(32'h3F800000, 1'b0);
    s_exists = 1'b0;
    check("t6_rel_err", {31'd0, err}, 32'd1);
    check("t6_rel_write", {31'd0, m_write}, 32'd0);

    // rerun 3 after reload to confirm recovery and the last-word flags
    load_matrix();
    check("t6_reload_mvalid", {31'd0, mvalid}, 32'd1);
    push_pixel();
    collect(32, -1, -1);
    verify(32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
